// File: rtl/pipeline_hazard_ctrl.sv
// Decode/ALU hazard, branch-flush and multicycle-stall controller (RUN / MC_WAIT / FLUSH).
// Optional stall_cycles counter is built only when HAZARD_STALL_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int N_WR      = 3,
    parameter int MC_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_AW-1:0]      dec_rs1,
    input  logic [REG_AW-1:0]      dec_rs2,
    input  logic                   dec_use1,
    input  logic                   dec_use2,
    input  logic [N_WR-1:0]        wr_valid,
    input  logic [N_WR*REG_AW-1:0] wr_rd,
    input  logic                   mc_start,
    input  logic                   br_valid,
    input  logic                   br_taken,
    input  logic                   br_pred,
    input  logic                   jalr_valid,
    output logic                   fetch_en,
    output logic                   dec_latch_en,
    output logic                   ra_latch_en,
    output logic                   alu_latch_en,
    output logic                   dec_x,
    output logic                   ra_x,
    output logic                   alu_x,
    output logic                   redirect,
    output logic                   mc_busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cycles
`endif
);

    typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;

    localparam logic [7:0] MC_LOAD = 8'(MC_CYCLES - 2);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       hazard;
    logic       mispredict;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < N_WR; i++) begin
            if (wr_valid[i] && (wr_rd[i*REG_AW +: REG_AW] != '0)) begin
                if ((dec_use1 && (dec_rs1 == wr_rd[i*REG_AW +: REG_AW])) ||
                    (dec_use2 && (dec_rs2 == wr_rd[i*REG_AW +: REG_AW])))
                    hazard = 1'b1;
            end
        end
    end

    assign mispredict = (br_valid && (br_taken ^ br_pred)) || jalr_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        fetch_en     = 1'b1;
        dec_latch_en = 1'b1;
        ra_latch_en  = 1'b1;
        alu_latch_en = 1'b1;
        dec_x        = 1'b0;
        ra_x         = 1'b0;
        alu_x        = 1'b0;
        redirect     = 1'b0;
        mc_busy      = 1'b0;
        case (state)
            RUN: begin
                if (mispredict) begin
                    redirect  = 1'b1;
                    dec_x     = 1'b1;
                    ra_x      = 1'b1;
                    state_nxt = FLUSH;
                end else if (mc_start) begin
                    fetch_en     = 1'b0;
                    dec_latch_en = 1'b0;
                    ra_latch_en  = 1'b0;
                    alu_latch_en = 1'b0;
                    alu_x        = 1'b1;
                    cnt_nxt      = MC_LOAD;
                    state_nxt    = MC_WAIT;
                end else if (hazard) begin
                    fetch_en     = 1'b0;
                    dec_latch_en = 1'b0;
                    ra_x         = 1'b1;
                end
            end
            MC_WAIT: begin
                fetch_en     = 1'b0;
                dec_latch_en = 1'b0;
                ra_latch_en  = 1'b0;
                alu_latch_en = 1'b0;
                alu_x        = 1'b1;
                mc_busy      = 1'b1;
                // Exit is checked before decrementing, so cnt never wraps.
                if (cnt == 8'd0)
                    state_nxt = RUN;
                else
                    cnt_nxt = cnt - 8'd1;
            end
            FLUSH: begin
                dec_x     = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
        if (rst) begin
            fetch_en     = 1'b0;
            dec_latch_en = 1'b0;
            ra_latch_en  = 1'b0;
            alu_latch_en = 1'b0;
            dec_x        = 1'b1;
            ra_x         = 1'b1;
            alu_x        = 1'b1;
            redirect     = 1'b0;
            mc_busy      = 1'b0;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= 32'd0;
        else if (!fetch_en && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: driver queues the expected output vector per cycle, monitor compares at negedge.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  dec_rs1, dec_rs2;
    logic        dec_use1, dec_use2;
    logic [2:0]  wr_valid;
    logic [14:0] wr_rd;
    logic        mc_start, br_valid, br_taken, br_pred, jalr_valid;
    logic        fetch_en, dec_latch_en, ra_latch_en, alu_latch_en;
    logic        dec_x, ra_x, alu_x, redirect, mc_busy;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    pipeline_hazard_ctrl #(.REG_AW(5), .N_WR(3), .MC_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use1(dec_use1), .dec_use2(dec_use2),
        .wr_valid(wr_valid), .wr_rd(wr_rd), .mc_start(mc_start),
        .br_valid(br_valid), .br_taken(br_taken), .br_pred(br_pred), .jalr_valid(jalr_valid),
        .fetch_en(fetch_en), .dec_latch_en(dec_latch_en), .ra_latch_en(ra_latch_en),
        .alu_latch_en(alu_latch_en), .dec_x(dec_x), .ra_x(ra_x), .alu_x(alu_x),
        .redirect(redirect), .mc_busy(mc_busy)
`ifdef HAZARD_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // {fetch_en, dec_latch_en, ra_latch_en, alu_latch_en, dec_x, ra_x, alu_x, redirect, mc_busy}
    localparam logic [8:0] V_DEF   = 9'b1111_000_0_0;
    localparam logic [8:0] V_RST   = 9'b0000_111_0_0;
    localparam logic [8:0] V_HAZ   = 9'b0011_010_0_0;
    localparam logic [8:0] V_MISP  = 9'b1111_110_1_0;
    localparam logic [8:0] V_FLUSH = 9'b1111_100_0_0;
    localparam logic [8:0] V_MCS   = 9'b0000_001_0_0;
    localparam logic [8:0] V_MCW   = 9'b0000_001_0_1;

    typedef struct {
        logic [8:0]  v;
        logic [31:0] st;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_st = 32'd0;

    task automatic idle();
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_use1 = 1'b0; dec_use2 = 1'b0;
        wr_valid = 3'b000; wr_rd = 15'd0; mc_start = 1'b0;
        br_valid = 1'b0; br_taken = 1'b0; br_pred = 1'b0; jalr_valid = 1'b0;
    endtask

    // Queue the expectation for the cycle now being driven, then advance one cycle.
    task automatic step(input logic [8:0] v, input string name);
        exp_t e;
        e.v = v; e.st = model_st; e.name = name;
        q.push_back(e);
        if (rst) model_st = 32'd0;
        else if (!v[8] && model_st != 32'hFFFF_FFFF) model_st = model_st + 32'd1;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [8:0] act;
            e   = q.pop_front();
            act = {fetch_en, dec_latch_en, ra_latch_en, alu_latch_en,
                   dec_x, ra_x, alu_x, redirect, mc_busy};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: outputs got %b required %b", e.name, act, e.v);
            end
`ifdef HAZARD_STALL_CNT_EN
            checks++;
            if (stall_cycles !== e.st) begin
                errors++;
                $display("FAIL %s stall_cycles: got %0d required %0d", e.name, stall_cycles, e.st);
            end
`endif
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk); #1;
        step(V_RST, "reset0");
        step(V_RST, "reset1");
        rst = 1'b0;
        step(V_DEF, "idle");

        // RAW on alu-stage writer, held three cycles
        wr_valid = 3'b010; wr_rd = {5'd0, 5'd5, 5'd0}; dec_rs1 = 5'd5; dec_use1 = 1'b1;
        step(V_HAZ, "haz_alu_rs1_a");
        step(V_HAZ, "haz_alu_rs1_b");
        step(V_HAZ, "haz_alu_rs1_c");
        wr_rd = 15'd0; dec_rs1 = 5'd0;
        step(V_DEF, "haz_rd0_none");
        idle();

        // Multicycle op, MC_CYCLES=4: start + 3 wait cycles
        mc_start = 1'b1;
        step(V_MCS, "mc_start");
        mc_start = 1'b0;
        step(V_MCW, "mc_wait1");
        step(V_MCW, "mc_wait2");
        step(V_MCW, "mc_wait3");
        step(V_DEF, "mc_done_stall7");

        // Branch mispredict; hazard during FLUSH ignored
        br_valid = 1'b1; br_pred = 1'b1; br_taken = 1'b0;
        step(V_MISP, "br_misp");
        idle();
        wr_valid = 3'b001; wr_rd = {5'd0, 5'd0, 5'd7}; dec_rs2 = 5'd7; dec_use2 = 1'b1;
        step(V_FLUSH, "flush_haz_ignored");
        step(V_HAZ, "haz_ra_rs2");
        dec_use2 = 1'b0;
        step(V_DEF, "haz_unused_src");
        idle();
        br_valid = 1'b1; br_pred = 1'b1; br_taken = 1'b1;
        step(V_DEF, "br_correct");
        idle();

        // Mispredict + mc_start + hazard together: flush only
        br_valid = 1'b1; br_pred = 1'b0; br_taken = 1'b1; mc_start = 1'b1;
        wr_valid = 3'b100; wr_rd = {5'd9, 5'd0, 5'd0}; dec_rs1 = 5'd9; dec_use1 = 1'b1;
        step(V_MISP, "prio_misp");
        idle();
        step(V_FLUSH, "prio_flush");
        step(V_DEF, "prio_run");

        jalr_valid = 1'b1;
        step(V_MISP, "jalr");
        idle();
        step(V_FLUSH, "jalr_flush");

        // Inputs during MC_WAIT are ignored
        mc_start = 1'b1;
        step(V_MCS, "mc2_start");
        br_valid = 1'b1; br_pred = 1'b1; jalr_valid = 1'b1;
        wr_valid = 3'b010; wr_rd = {5'd0, 5'd3, 5'd0}; dec_rs1 = 5'd3; dec_use1 = 1'b1;
        step(V_MCW, "mc2_wait1");
        step(V_MCW, "mc2_wait2");
        step(V_MCW, "mc2_wait3");
        idle();
        step(V_DEF, "mc2_done");

        // Reset in 2nd MC_WAIT cycle
        mc_start = 1'b1;
        step(V_MCS, "mc3_start");
        mc_start = 1'b0;
        step(V_MCW, "mc3_wait1");
        rst = 1'b1;
        step(V_RST, "mc3_rst");
        rst = 1'b0;
        step(V_DEF, "mc3_after_rst");

        // Reset during FLUSH
        jalr_valid = 1'b1;
        step(V_MISP, "fl_misp");
        jalr_valid = 1'b0;
        rst = 1'b1;
        step(V_RST, "fl_rst");
        rst = 1'b0;
        step(V_DEF, "fl_after_rst");

        // Register 0 never hazards
        wr_valid = 3'b111; wr_rd = 15'd0; dec_use1 = 1'b1; dec_use2 = 1'b1;
        step(V_DEF, "reg0_all");
        idle();

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: pending %0d required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters SHALL be:
- REG_AW, default 5: register address width.
- N_WR, default 3: number of in-flight writer stages checked.
- MC_CYCLES, default 4, legal range 2..255: multicycle ALU op latency in cycles.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- dec_rs1, dec_rs2  in  REG_AW each  decode-stage source registers.
- dec_use1, dec_use2  in  1 each  the corresponding source is actually read.
- wr_valid  in  N_WR  writer stage i holds a register-writing instruction; i=0 is reg_access, i=1 is alu, i=2 is post_alu, and so on.
- wr_rd  in  N_WR*REG_AW  destination of writer i, in bits [i*REG_AW +: REG_AW].
- mc_start  in  1  a multicycle op is in ALU this cycle.
- br_valid  in  1  a conditional branch is in ALU.
- br_taken  in  1  resolved branch direction.
- br_pred  in  1  predicted branch direction.
- jalr_valid  in  1  a JALR is resolving in ALU.
- fetch_en, dec_latch_en, ra_latch_en, alu_latch_en  out  1 each  stage latch enables.
- dec_x, ra_x, alu_x  out  1 each  load a bubble into that stage's output latch.
- redirect  out  1  jump control enable; fetch takes the resolved target.
- mc_busy  out  1  high while the FSM is in MC_WAIT.

Function
REQ-003 hazard SHALL be 1 iff, for some i, wr_valid[i] is set, wr_rd[i] is nonzero, and (dec_use1 and dec_rs1 equals wr_rd[i]) or (dec_use2 and dec_rs2 equals wr_rd[i]); register 0 SHALL never cause a hazard.
REQ-004 mispredict SHALL be (br_valid and (br_taken XOR br_pred)) or jalr_valid.
REQ-005 The FSM SHALL have three states: RUN, MC_WAIT and FLUSH.
REQ-006 Outputs SHALL be combinational from state and inputs; defaults are all latch enables 1, all x outputs 0, redirect 0.
REQ-007 In RUN with mispredict: redirect=1, dec_x=1, ra_x=1, fetch_en=1. The next state SHALL be FLUSH, and hazard and mc_start SHALL be ignored that cycle.
REQ-008 In RUN with mc_start and no mispredict:
- fetch_en, dec_latch_en, ra_latch_en and alu_latch_en SHALL be 0 and alu_x=1.
- The counter SHALL load MC_CYCLES-2 and the next state SHALL be MC_WAIT.
REQ-009 In RUN with hazard and neither mispredict nor mc_start: fetch_en=0, dec_latch_en=0, ra_x=1 (bubble into reg_access), and the state SHALL stay RUN.
REQ-010 In MC_WAIT, outputs SHALL be as in REQ-008 and the counter SHALL decrement each cycle. When the counter is 0 the state SHALL return to RUN. Total ALU hold is exactly MC_CYCLES-1 cycles, plus the completing cycle.
REQ-011 In MC_WAIT, br_valid, jalr_valid, mc_start and hazard SHALL be ignored.
REQ-012 In FLUSH: dec_x=1 (squashes the wrong-path fetch), redirect=0, other outputs at default. The state SHALL be RUN on the next cycle unconditionally.
REQ-013 A hazard present in FLUSH SHALL be ignored, because the decode contents are squashed.
REQ-014 Priority within a cycle SHALL be: rst, then mispredict, then mc_start, then hazard.
REQ-015 The counter width SHALL be 8 bits; it SHALL never wrap, because the MC_WAIT exit at 0 precedes any decrement.

Reset
REQ-016 While rst=1 at a clock edge: state becomes RUN, counter becomes 0, and the stall counter (when present) becomes 0.
REQ-017 While rst is high, outputs SHALL be: all latch enables 0, dec_x=ra_x=alu_x=1, redirect=0, mc_busy=0.
REQ-018 Asserting rst mid-MC_WAIT or mid-FLUSH SHALL abort that operation with no residual stall.

Configuration
REQ-019 With macro HAZARD_STALL_CNT_EN defined:
- An output stall_cycles (out, 32) SHALL count every cycle in which fetch_en=0 while rst=0.
- It SHALL saturate at 0xFFFFFFFF.
REQ-020 Without HAZARD_STALL_CNT_EN, the stall_cycles port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-021 Setup: wr_valid=3'b010, alu rd=5, dec_rs1=5, dec_use1=1. Required: fetch_en=0, dec_latch_en=0, ra_x=1, state RUN. Repeat the setup with rd=0: no stall.
REQ-022 Setup: br_valid=1, br_pred=1, br_taken=0. Required: redirect=1, dec_x=ra_x=1 in that cycle; next cycle dec_x=1, redirect=0; the cycle after, all defaults.
REQ-023 Setup: mc_start pulse with MC_CYCLES=4. Required: mc_busy high for exactly 3 cycles after the start cycle, alu_latch_en=0 for 4 cycles total, then RUN.
REQ-024 Setup: mispredict and mc_start and hazard asserted in the same cycle. Required: only the flush response of REQ-007; the state never enters MC_WAIT.
REQ-025 Setup: rst asserted in the 2nd MC_WAIT cycle. Required: on the next cycle state is RUN, mc_busy=0, and the stall counter equals 0.
REQ-026 With HAZARD_STALL_CNT_EN: after the 3-cycle hazard stall and the REQ-023 sequence, stall_cycles=7.
